tx_sync: RTL and testbench

Start-up sequencer for the transmit side of the DDR gearing interface. It waits for the transmit PLL to lock and for an `init` request. It then runs the fixed bring-up order on the edge-clock synchroniser and the clock divider/output gearbox: stop the edge clock, release the divider reset, restart the edge clock, and report ready. It sits between the PLL lock output and the ECLKSYNC stop, CLKDIV/ODDR reset and tx-path enable, clocked by the slow system clock.

---
 rtl/tx_sync_if.sv | 27 ++
 rtl/tx_sync.sv | 99 +++++++++
 tb/tb_tx_sync.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_sync_if.sv
// tx_sync_if: control bundle between the tx start-up sequencer and the
// surrounding gearing logic (request/lock in, clock-sync/gearbox controls out).
interface tx_sync_if;
    logic init;
    logic lock;
    logic eclk_stop;
    logic div_reset;
    logic tx_ready;

    // Driven by the system side and the PLL; observes the sequencer outputs.
    modport master (
        output init,
        output lock,
        input  eclk_stop,
        input  div_reset,
        input  tx_ready
    );

    // The sequencer itself.
    modport slave (
        input  init,
        input  lock,
        output eclk_stop,
        output div_reset,
        output tx_ready
    );
endinterface

// File: rtl/tx_sync.sv
// tx_sync: transmit-side DDR gearing start-up sequencer. Waits for PLL lock
// and an init request, then stops the edge clock, releases the divider and
// gearbox reset, restarts the edge clock and reports ready. Losing lock or
// init at any point drops straight back to the idle, divider-in-reset state.
module tx_sync #(
    parameter int WAIT_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic      clk,
    input  logic      rst,
    tx_sync_if.slave  bus
);

    typedef enum logic [5:0] {
        WAIT_LOCK = 6'b000001,
        SETTLE    = 6'b000010,
        STOP      = 6'b000100,
        REL_RST   = 6'b001000,
        START     = 6'b010000,
        READY     = 6'b100000
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             lock_p1;
    logic             lock_s;
    logic             abort;
    logic             done;
    logic             eclk_stop_q;
    logic             div_reset_q;
    logic             tx_ready_q;

    // Two-flop synchroniser bringing the asynchronous PLL lock into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_p1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p1 <= bus.lock;
            lock_s  <= lock_p1;
        end
    end

    assign abort = ~bus.init | ~lock_s;
    assign done  = (cnt == CNT_LAST);

    // Next-state selection; abort outranks dwell completion in every active state.
    always_comb begin
        state_nxt = state;
        if (state != WAIT_LOCK && abort) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: if (bus.init && lock_s) state_nxt = SETTLE;
                SETTLE:    if (done)               state_nxt = STOP;
                STOP:      if (done)               state_nxt = REL_RST;
                REL_RST:   if (done)               state_nxt = START;
                START:     if (done)               state_nxt = READY;
                READY:                             state_nxt = READY;
                default:                           state_nxt = WAIT_LOCK;
            endcase
        end
    end

    // State, dwell counter and outputs, with outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            eclk_stop_q <= 1'b0;
            div_reset_q <= 1'b1;
            tx_ready_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            case (state_nxt)
                SETTLE:  begin eclk_stop_q <= 1'b0; div_reset_q <= 1'b1; tx_ready_q <= 1'b0; end
                STOP:    begin eclk_stop_q <= 1'b1; div_reset_q <= 1'b1; tx_ready_q <= 1'b0; end
                REL_RST: begin eclk_stop_q <= 1'b1; div_reset_q <= 1'b0; tx_ready_q <= 1'b0; end
                START:   begin eclk_stop_q <= 1'b0; div_reset_q <= 1'b0; tx_ready_q <= 1'b0; end
                READY:   begin eclk_stop_q <= 1'b0; div_reset_q <= 1'b0; tx_ready_q <= 1'b1; end
                default: begin eclk_stop_q <= 1'b0; div_reset_q <= 1'b1; tx_ready_q <= 1'b0; end
            endcase
        end
    end

    assign bus.eclk_stop = eclk_stop_q;
    assign bus.div_reset = div_reset_q;
    assign bus.tx_ready  = tx_ready_q;

endmodule

// File: tb/tb_tx_sync.sv
// tb_tx_sync: scoreboard bench for tx_sync. Two instances (WAIT_CYC=4 and
// WAIT_CYC=2) share the same stimulus; a progress-based reference model
// predicts their outputs per edge and a monitor compares them.
module tb_tx_sync;

    logic clk = 1'b0;
    logic rst;

    tx_sync_if bus4 ();
    tx_sync_if bus2 ();

    tx_sync #(.WAIT_CYC(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    tx_sync #(.WAIT_CYC(2), .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    // Free-running system clock.
    always #5 clk = ~clk;

    typedef struct {
        int         step;
        logic [2:0] e4;
        logic [2:0] e2;
    } exp_t;

    exp_t exp_q[$];

    int checks      = 0;
    int failures    = 0;
    int step_count  = 0;

    // Reference model: cycles spent since bring-up began (-1 = idle), plus the lock delay line.
    int   prog4 = -1;
    int   prog2 = -1;
    logic m_p1  = 1'b0;
    logic m_s   = 1'b0;

    int stop_rise4  = -1;
    int div_fall4   = -1;
    int ready_rise4 = -1;
    int ready_rise2 = -1;
    int stop_rise2  = -1;

    logic [2:0] prev4 = 3'b010;
    logic [2:0] prev2 = 3'b010;
    logic [2:0] act4;
    logic [2:0] act2;
    exp_t       mon_e;

    // Outputs {eclk_stop, div_reset, tx_ready} as a function of bring-up progress.
    function automatic logic [2:0] expect_out(input int prog, input int w);
        if (prog < 0) return 3'b010;
        case (prog / w)
            0:       return 3'b010;
            1:       return 3'b110;
            2:       return 3'b100;
            3:       return 3'b000;
            default: return 3'b001;
        endcase
    endfunction

    function automatic int advance(input int prog, input int w, input logic ab);
        if (prog < 0) return ab ? -1 : 0;
        if (ab) return -1;
        return (prog < 4 * w) ? prog + 1 : prog;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive one edge's worth of inputs and queue the model's prediction for that edge.
    task automatic applyStimulus(input logic r, input logic i, input logic l);
        exp_t e;
        logic ab;
        @(negedge clk);
        rst       = r;
        bus4.init = i;
        bus4.lock = l;
        bus2.init = i;
        bus2.lock = l;
        step_count++;
        if (r) begin
            prog4 = -1;
            prog2 = -1;
            m_p1  = 1'b0;
            m_s   = 1'b0;
        end else begin
            ab    = !i || !m_s;
            prog4 = advance(prog4, 4, ab);
            prog2 = advance(prog2, 2, ab);
            m_s   = m_p1;
            m_p1  = l;
        end
        e.step = step_count;
        e.e4   = expect_out(prog4, 4);
        e.e2   = expect_out(prog2, 2);
        exp_q.push_back(e);
    endtask

    task automatic clearRecords();
        stop_rise4  = -1;
        div_fall4   = -1;
        ready_rise4 = -1;
        ready_rise2 = -1;
        stop_rise2  = -1;
    endtask

    // Monitor: one prediction per edge, compared just after the edge, plus ordering rules.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            act4  = {bus4.eclk_stop, bus4.div_reset, bus4.tx_ready};
            act2  = {bus2.eclk_stop, bus2.div_reset, bus2.tx_ready};
            checkOutput($sformatf("dut4_outputs_step%0d", mon_e.step), int'(act4), int'(mon_e.e4));
            checkOutput($sformatf("dut2_outputs_step%0d", mon_e.step), int'(act2), int'(mon_e.e2));
            if (prev4[1] && !act4[1]) checkOutput("dut4_div_fall_needs_stop", int'(act4[2]), 1);
            if (prev2[1] && !act2[1]) checkOutput("dut2_div_fall_needs_stop", int'(act2[2]), 1);
            if (!prev4[2] && act4[2]) checkOutput("dut4_stop_rise_needs_div", int'(prev4[1]), 1);
            if (!prev2[2] && act2[2]) checkOutput("dut2_stop_rise_needs_div", int'(prev2[1]), 1);
            if (!prev4[2] && act4[2] && stop_rise4 < 0)  stop_rise4  = mon_e.step;
            if (prev4[1] && !act4[1] && div_fall4 < 0)   div_fall4   = mon_e.step;
            if (!prev4[0] && act4[0] && ready_rise4 < 0) ready_rise4 = mon_e.step;
            if (!prev2[2] && act2[2] && stop_rise2 < 0)  stop_rise2  = mon_e.step;
            if (!prev2[0] && act2[0] && ready_rise2 < 0) ready_rise2 = mon_e.step;
            prev4 = act4;
            prev2 = act2;
        end
    end

    // Scenario sequence followed by randomized traffic.
    initial begin
        int   base;
        logic r_init;
        logic r_lock;
        rst       = 1'b1;
        bus4.init = 1'b0;
        bus4.lock = 1'b0;
        bus2.init = 1'b0;
        bus2.lock = 1'b0;

        // Nominal bring-up: two reset cycles, then init high and lock rising before edge 1.
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
        clearRecords();
        base = step_count;
        repeat (25) applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("nominal_stop_rise_edge",  stop_rise4 - base, 7);
        checkOutput("nominal_div_fall_edge",   div_fall4 - base, 11);
        checkOutput("nominal_ready_rise_edge", ready_rise4 - base, 19);
        checkOutput("w2_stop_rise_edge",       stop_rise2 - base, 5);
        checkOutput("w2_ready_rise_edge",      ready_rise2 - base, 11);

        // Lock loss while in STOP, then full re-run.
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (7) applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        clearRecords();
        base = step_count;
        repeat (25) applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("relock_ready_rise_edge", ready_rise4 - base, 19);

        // init withdrawal from READY and re-assertion.
        clearRecords();
        applyStimulus(1'b0, 1'b0, 1'b1);
        base = step_count;
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("reinit_ready_after_drop",    ready_rise4 - base, 17);
        checkOutput("w2_reinit_ready_after_drop", ready_rise2 - base, 9);

        // Lock present but no init: nothing may start.
        clearRecords();
        repeat (100) applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("noinit_no_stop_rise", stop_rise4, -1);
        checkOutput("noinit_no_ready",     ready_rise4, -1);

        // Reset pulse in the middle of the divider-release dwell.
        repeat (12) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        clearRecords();
        base = step_count + 1;
        repeat (25) applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("midrst_stop_rise_after_release",  stop_rise4 - base, 6);
        checkOutput("midrst_ready_rise_after_release", ready_rise4 - base, 18);
        checkOutput("w2_midrst_ready_after_release",   ready_rise2 - base, 10);

        // Randomized traffic on init, lock and occasional reset.
        r_init = 1'b1;
        r_lock = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) r_init = ~r_init;
            if ($urandom_range(0, 14) == 0) r_lock = ~r_lock;
            applyStimulus(($urandom_range(0, 49) == 0), r_init, r_lock);
        end
        @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
